// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared types and helpers for the arbitrated register bank
package reg_bank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam int REQ_N = 2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_rw.sv
// rtl/reg_rw.sv - single config register with write enable and reset value
module reg_rw #(
    parameter int                 BITS_W    = 32,
    parameter logic [BITS_W-1:0]  DEFAULT_V = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [BITS_W-1:0] w_dat,
    output logic [BITS_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= DEFAULT_V;
        end else if (w_en) begin
            q <= w_dat;
        end
    end

endmodule

// File: rtl/reg_bank_arb.sv
// rtl/reg_bank_arb.sv - two-requester round-robin arbitrated register bank
module reg_bank_arb
    import reg_bank_pkg::*;
#(
    parameter int                 BITS_W    = 32,
    parameter int                 REG_NUM   = 8,
    parameter int                 ADDR_W    = 3,
    parameter logic [BITS_W-1:0]  DEFAULT_V = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0,
    input  logic                      req1,
    input  logic                      wr0,
    input  logic                      wr1,
    input  logic [ADDR_W-1:0]         addr0,
    input  logic [ADDR_W-1:0]         addr1,
    input  logic [BITS_W-1:0]         wdat0,
    input  logic [BITS_W-1:0]         wdat1,
    output logic                      gnt0,
    output logic                      gnt1,
    output logic                      rvld0,
    output logic                      rvld1,
    output logic [BITS_W-1:0]         rdat0,
    output logic [BITS_W-1:0]         rdat1,
    output logic [REG_NUM*BITS_W-1:0] dout_all
);

    if (clog2(REG_NUM) > ADDR_W || REG_NUM < 2 || REG_NUM > 256) begin : g_bad_cfg
        $error("reg_bank_arb: REG_NUM out of range or ADDR_W too narrow");
    end

    state_t              state;
    logic                last_gnt;
    logic                lat_port;
    logic                lat_wr;
    logic [ADDR_W-1:0]   lat_addr;
    logic [BITS_W-1:0]   lat_wdat;
    logic [REQ_N-1:0]    req_v;
    logic                win;
    logic                in_range;
    logic [BITS_W-1:0]   rd_val;
    logic [BITS_W-1:0]   regs [REG_NUM];

    assign req_v = {req1, req0};

    // last_gnt holds the most recently granted port; on contention the other one wins
    assign win      = req_v[1] & (~req_v[0] | ~last_gnt);
    assign in_range = int'(lat_addr) < REG_NUM;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (lat_addr == ADDR_W'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
            lat_port <= 1'b0;
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_wdat <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvld0    <= 1'b0;
            rvld1    <= 1'b0;
            rdat0    <= '0;
            rdat1    <= '0;
        end else begin
            rvld0 <= 1'b0;
            rvld1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_v) begin
                        lat_port <= win;
                        lat_wr   <= win ? wr1   : wr0;
                        lat_addr <= win ? addr1 : addr0;
                        lat_wdat <= win ? wdat1 : wdat0;
                        gnt0     <= ~win;
                        gnt1     <= win;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    last_gnt <= lat_port;
                    // read data is sampled before this cycle's write lands
                    if (!lat_wr) begin
                        if (lat_port) begin
                            rvld1 <= 1'b1;
                            rdat1 <= in_range ? rd_val : '0;
                        end else begin
                            rvld0 <= 1'b1;
                            rdat0 <= in_range ? rd_val : '0;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
        logic w_en;

        assign w_en = (state == ACC) & lat_wr & (lat_addr == ADDR_W'(i)) & in_range;

        reg_rw #(
            .BITS_W    (BITS_W),
            .DEFAULT_V (DEFAULT_V)
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .w_en  (w_en),
            .w_dat (lat_wdat),
            .q     (regs[i])
        );

        assign dout_all[i*BITS_W +: BITS_W] = regs[i];
    end

endmodule

// File: tb/tb_reg_bank_arb.sv
// tb/tb_reg_bank_arb.sv - directed self-checking bench for reg_bank_arb
module tb_reg_bank_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic         wr0 = 1'b0, wr1 = 1'b0;
    logic [3:0]   addr0 = '0, addr1 = '0;
    logic [31:0]  wdat0 = '0, wdat1 = '0;

    logic         a_gnt0, a_gnt1, a_rvld0, a_rvld1;
    logic [31:0]  a_rdat0, a_rdat1;
    logic [255:0] a_dout;
    logic         b_gnt0, b_gnt1, b_rvld0, b_rvld1;
    logic [31:0]  b_rdat0, b_rdat1;
    logic [255:0] b_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_bank_arb #(.BITS_W(32), .REG_NUM(8), .ADDR_W(3), .DEFAULT_V(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0[2:0]), .addr1(addr1[2:0]), .wdat0(wdat0), .wdat1(wdat1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .rvld0(a_rvld0), .rvld1(a_rvld1),
        .rdat0(a_rdat0), .rdat1(a_rdat1), .dout_all(a_dout)
    );

    reg_bank_arb #(.BITS_W(32), .REG_NUM(8), .ADDR_W(4), .DEFAULT_V(32'h0)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvld0(b_rvld0), .rvld1(b_rvld1),
        .rdat0(b_rdat0), .rdat1(b_rdat1), .dout_all(b_dout)
    );

    typedef struct {
        bit          port;
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdat;
        logic [31:0] exp_rdat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input bit port, input bit r, input bit wr, input logic [3:0] addr,
                         input logic [31:0] wdat);
        if (port) begin
            req1 = r; wr1 = wr; addr1 = addr; wdat1 = wdat;
        end else begin
            req0 = r; wr0 = wr; addr0 = addr; wdat0 = wdat;
        end
    endtask

    // starts at a negedge with the FSM idle, ends at the negedge of the rvld cycle
    task automatic access(input bit sel, input bit port, input bit wr, input logic [3:0] addr,
                          input logic [31:0] wdat, input logic [31:0] exp_rdat);
        logic g0, g1, v0, v1;
        logic [31:0] rd;
        drive(port, 1'b1, wr, addr, wdat);
        @(negedge clk);
        g0 = sel ? b_gnt0 : a_gnt0;
        g1 = sel ? b_gnt1 : a_gnt1;
        chk("acc gnt winner", 32'(port ? g1 : g0), 32'd1);
        chk("acc gnt loser",  32'(port ? g0 : g1), 32'd0);
        drive(port, 1'b0, wr, addr, wdat);
        @(negedge clk);
        v0 = sel ? b_rvld0 : a_rvld0;
        v1 = sel ? b_rvld1 : a_rvld1;
        rd = port ? (sel ? b_rdat1 : a_rdat1) : (sel ? b_rdat0 : a_rdat0);
        chk("acc rvld own",   32'(port ? v1 : v0), 32'(!wr));
        chk("acc rvld other", 32'(port ? v0 : v1), 32'd0);
        if (!wr) chk("acc rdat", rd, exp_rdat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] g0_pat;
        logic [7:0] g1_pat;

        vecs[0] = '{1'b0, 1'b1, 4'd2, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 4'd2, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 4'd0, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 4'd0, 32'h0,        32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 4'd7, 32'hA5A5A5A5, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 4'd7, 32'h0,        32'hA5A5A5A5};
        vecs[6] = '{1'b1, 1'b0, 4'd5, 32'h0,        32'h0};

        do_reset();
        chk("reset gnt0",  32'(a_gnt0),  32'd0);
        chk("reset gnt1",  32'(a_gnt1),  32'd0);
        chk("reset rvld0", 32'(a_rvld0), 32'd0);
        chk("reset rvld1", 32'(a_rvld1), 32'd0);
        chk("reset rdat0", a_rdat0, 32'h0);
        chk("reset rdat1", a_rdat1, 32'h0);
        for (int i = 0; i < 8; i++) chk("reset dout", a_dout[i*32 +: 32], 32'h0);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            access(1'b0, vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdat, vecs[i].exp_rdat);
            if (vecs[i].wr)
                chk("table dout", a_dout[int'(vecs[i].addr)*32 +: 32], vecs[i].wdat);
        end

        // contention from reset: pointer 0 means port 1 wins first, then alternate
        do_reset();
        g0_pat = 8'b0000_1000;
        g1_pat = 8'b0010_0010;
        drive(1'b0, 1'b1, 1'b0, 4'd1, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'd1, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("rr gnt0", 32'(a_gnt0), 32'(g0_pat[c]));
            chk("rr gnt1", 32'(a_gnt1), 32'(g1_pat[c]));
            if (c == 5) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end

        // last grant was port 1, so the port 0 write goes first
        drive(1'b0, 1'b1, 1'b1, 4'd7, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 4'd7, 32'h0);
        @(negedge clk);
        chk("order gnt0 first", 32'(a_gnt0), 32'd1);
        chk("order gnt1 held",  32'(a_gnt1), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        chk("order reg7 written", a_dout[7*32 +: 32], 32'h1);
        chk("order idle gap", 32'(a_gnt0 | a_gnt1), 32'd0);
        @(negedge clk);
        chk("order gnt1 second", 32'(a_gnt1), 32'd1);
        req1 = 1'b0;
        @(negedge clk);
        chk("order rvld1", 32'(a_rvld1), 32'd1);
        chk("order rdat1", a_rdat1, 32'h1);

        // out-of-range addressing on the ADDR_W=4 instance
        do_reset();
        @(negedge clk);
        access(1'b1, 1'b1, 1'b1, 4'd1, 32'hCAFEF00D, 32'h0);
        access(1'b1, 1'b1, 1'b0, 4'd1, 32'h0, 32'hCAFEF00D);
        access(1'b1, 1'b1, 1'b1, 4'd9, 32'hFFFFFFFF, 32'h0);
        access(1'b1, 1'b0, 1'b1, 4'd8, 32'h87654321, 32'h0);
        for (int i = 0; i < 8; i++)
            chk("oor dout", b_dout[i*32 +: 32], (i == 1) ? 32'hCAFEF00D : 32'h0);
        access(1'b1, 1'b1, 1'b0, 4'd9, 32'h0, 32'h0);

        // reset asserted inside the ACC cycle of a write aborts it
        drive(1'b0, 1'b1, 1'b1, 4'd3, 32'h55);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("abort reg3", a_dout[3*32 +: 32], 32'h0);
            chk("abort gnt",  32'(a_gnt0 | a_gnt1), 32'd0);
            chk("abort rvld", 32'(a_rvld0 | a_rvld1), 32'd0);
            @(negedge clk);
        end
        access(1'b0, 1'b0, 1'b1, 4'd3, 32'h77, 32'h0);
        chk("post-abort reg3", a_dout[3*32 +: 32], 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
